// File: rtl/lru_alloc_ctrl.sv
// Per-set controller in front of an lru_stack: arbitrates hit touches against miss
// allocations, tracks way valid bits and issues at most one stack update per cycle.
module lru_alloc_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             hit_req,
  input  logic [DEPTH-1:0] hit_way,
  output logic             hit_gnt,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [DEPTH-1:0] alloc_way,
  input  logic             alloc_done,
  output logic             alloc_err,
  input  logic             inval_req,
  input  logic [DEPTH-1:0] inval_way,
  output logic [DEPTH-1:0] valid_vec,
  output logic             busy,
  output logic             lru_update,
  output logic [DEPTH-1:0] lru_accessed_blk,
  input  logic [DEPTH-1:0] lru_victim_blk
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT, ALLOC} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] alloc_way_q, alloc_way_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             gnt_q, gnt_d;
  logic             err_q, err_d;
  logic             upd_q, upd_d;

  logic [DEPTH-1:0] valid_eff;
  logic [DEPTH-1:0] free_way;
  logic             any_free;
  logic             hit_ok;
  logic             force_alloc;
  logic             hit_gnt_c;
  logic             alloc_win;
  logic             commit;

  always_comb begin
    valid_eff   = valid_q & ~(inval_req ? inval_way : '0);
    commit      = (state_q == ALLOC) && alloc_done;
    hit_ok      = hit_req && (hit_way != '0) && !commit &&
                  !((state_q != IDLE) && (hit_way == alloc_way_q));
    force_alloc = (state_q == IDLE) && alloc_req && (starve_q == STARVE_LIM);
    hit_gnt_c   = hit_ok && !force_alloc;
    alloc_win   = (state_q == IDLE) && alloc_req && (!hit_ok || force_alloc);

    // Lowest-index invalid way, seen after any same-cycle invalidate.
    free_way = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_eff[i] && !any_free) begin
        free_way[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    alloc_way_d = alloc_way_q;
    starve_d    = starve_q;
    gnt_d       = alloc_win;
    err_d       = 1'b0;
    upd_d       = commit || hit_gnt_c;
    acc_d       = '0;
    valid_d     = valid_eff;

    if (!alloc_req || alloc_win) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && hit_gnt_c && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end

    if (alloc_win) begin
      if (any_free) begin
        alloc_way_d = free_way;
      end else if ($onehot(lru_victim_blk)) begin
        alloc_way_d = lru_victim_blk;
      end else begin
        alloc_way_d = '0;
        alloc_way_d[DEPTH-1] = 1'b1;
        err_d = 1'b1;
      end
    end

    // Commit overrides a same-edge invalidate of the filled way.
    if (commit) begin
      valid_d = valid_eff | alloc_way_q;
      acc_d   = alloc_way_q;
    end else if (hit_gnt_c) begin
      acc_d = hit_way;
    end

    unique case (state_q)
      IDLE:    if (alloc_win) state_d = GRANT;
      GRANT:   state_d = ALLOC;
      ALLOC:   if (alloc_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      alloc_way_q <= '0;
      valid_q     <= '0;
      acc_q       <= '0;
      starve_q    <= '0;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alloc_way_q <= alloc_way_d;
      valid_q     <= valid_d;
      acc_q       <= acc_d;
      starve_q    <= starve_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      upd_q       <= upd_d;
    end
  end

  assign hit_gnt          = hit_gnt_c;
  assign alloc_gnt        = gnt_q;
  assign alloc_way        = alloc_way_q;
  assign alloc_err        = err_q;
  assign valid_vec        = valid_q;
  assign busy             = (state_q != IDLE);
  assign lru_update       = upd_q;
  assign lru_accessed_blk = acc_q;

endmodule

// File: tb/tb_lru_alloc_ctrl.sv
// Bench for lru_alloc_ctrl (4 ways): a phase/index-level model plus an LRU stack model,
// checked every cycle, with directed scenarios carrying literal expectations.
module tb_lru_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       hit_req = 1'b0;
  logic [3:0] hit_way = '0;
  logic       hit_gnt;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  logic [3:0] alloc_way;
  logic       alloc_done = 1'b0;
  logic       alloc_err;
  logic       inval_req = 1'b0;
  logic [3:0] inval_way = '0;
  logic [3:0] valid_vec;
  logic       busy;
  logic       lru_update;
  logic [3:0] lru_accessed_blk;
  logic [3:0] lru_victim_blk;

  lru_alloc_ctrl #(.DEPTH(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .hit_req(hit_req), .hit_way(hit_way), .hit_gnt(hit_gnt),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_way(alloc_way),
    .alloc_done(alloc_done), .alloc_err(alloc_err),
    .inval_req(inval_req), .inval_way(inval_way), .valid_vec(valid_vec),
    .busy(busy), .lru_update(lru_update), .lru_accessed_blk(lru_accessed_blk),
    .lru_victim_blk(lru_victim_blk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // LRU stack model: ord[0] is least recently used.
  int         ord[4] = '{0, 1, 2, 3};
  logic       vic_ovr_en = 1'b0;
  logic [3:0] vic_ovr = '0;
  assign lru_victim_blk = vic_ovr_en ? vic_ovr : (4'b0001 << ord[0]);

  // Controller model: phase 0 idle, 1 grant, 2 alloc.
  int         m_ph, n_ph, m_starve, n_starve;
  logic [3:0] m_way, n_way, m_acc, n_acc;
  bit         m_valid[4], n_valid[4], av[4];
  logic       m_upd, n_upd, m_gnt, n_gnt, m_err, n_err;
  logic [3:0] vv;
  bit         hit_ok, force_a, exp_hg, win, found, commit;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_ph = 0; n_ph = 0; m_starve = 0; n_starve = 0;
      m_way = '0; n_way = '0; m_acc = '0; n_acc = '0;
      m_upd = 0; n_upd = 0; m_gnt = 0; n_gnt = 0; m_err = 0; n_err = 0;
      for (int i = 0; i < 4; i++) begin m_valid[i] = 0; n_valid[i] = 0; end
    end else begin
      if (m_upd) begin
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (m_acc == (4'b0001 << ord[i])) p = i;
        begin
          int w;
          w = ord[p];
          for (int i = p; i < 3; i++) ord[i] = ord[i+1];
          ord[3] = w;
        end
      end
      m_ph = n_ph; m_starve = n_starve; m_way = n_way; m_acc = n_acc;
      m_upd = n_upd; m_gnt = n_gnt; m_err = n_err; m_valid = n_valid;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 4; i++) vv[i] = m_valid[i];
      chk("valid_vec", valid_vec, vv);
      chk("busy", busy, m_ph != 0);
      chk("alloc_gnt", alloc_gnt, m_gnt);
      chk("alloc_err", alloc_err, m_err);
      chk("alloc_way", alloc_way, m_way);
      chk("lru_update", lru_update, m_upd);
      if (m_upd) chk("lru_accessed_blk", lru_accessed_blk, m_acc);

      commit  = (m_ph == 2) && alloc_done;
      hit_ok  = hit_req && (hit_way != 0) && !commit && !((m_ph != 0) && (hit_way == m_way));
      force_a = (m_ph == 0) && alloc_req && (m_starve == 3);
      exp_hg  = hit_ok && !force_a;
      win     = (m_ph == 0) && alloc_req && (!hit_ok || force_a);
      chk("hit_gnt", hit_gnt, exp_hg);

      n_starve = m_starve;
      if (!alloc_req || win) n_starve = 0;
      else if ((m_ph == 0) && exp_hg && n_starve < 3) n_starve = n_starve + 1;

      for (int i = 0; i < 4; i++) av[i] = m_valid[i] && !(inval_req && inval_way[i]);
      n_way = m_way; n_gnt = win; n_err = 0;
      if (win) begin
        found = 0;
        for (int i = 0; i < 4; i++)
          if (!found && !av[i]) begin n_way = 4'b0001 << i; found = 1; end
        if (!found) begin
          if ($countones(lru_victim_blk) == 1) n_way = lru_victim_blk;
          else begin n_way = 4'b1000; n_err = 1; end
        end
      end
      n_valid = av;
      if (commit) for (int i = 0; i < 4; i++) if (m_way[i]) n_valid[i] = 1;
      n_upd = commit || exp_hg;
      n_acc = commit ? m_way : hit_way;
      case (m_ph)
        0: n_ph = win ? 1 : 0;
        1: n_ph = 2;
        default: n_ph = alloc_done ? 0 : 2;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(output logic [3:0] w, output logic e);
    int k;
    alloc_req = 1'b1;
    k = 0;
    do begin cyc(); k++; end while (!alloc_gnt && k < 20);
    chk("alloc_gnt_seen", alloc_gnt, 1'b1);
    w = alloc_way;
    e = alloc_err;
    alloc_req = 1'b0;
    cyc();
    alloc_done = 1'b1;
    cyc();
    alloc_done = 1'b0;
  endtask

  task automatic starve_run(output int nh, output logic [3:0] w);
    nh = 0;
    hit_req = 1'b1; hit_way = 4'b0001; alloc_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (hit_gnt) nh++;
      cyc();
      if (alloc_gnt) break;
    end
    chk("starve_gnt_seen", alloc_gnt, 1'b1);
    w = alloc_way;
    hit_req = 1'b0; alloc_req = 1'b0;
    cyc();
    alloc_done = 1'b1;
    cyc();
    alloc_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] w;
    logic       e;
    int         nh;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_alloc_gnt", alloc_gnt, 1'b0);
    chk("rst_alloc_err", alloc_err, 1'b0);
    chk("rst_lru_update", lru_update, 1'b0);
    chk("rst_alloc_way", alloc_way, 4'b0000);
    chk("rst_accessed", lru_accessed_blk, 4'b0000);
    chk("rst_valid", valid_vec, 4'b0000);
    rst_b = 1'b1;
    cyc();

    // First allocation after reset takes way 0.
    alloc_req = 1'b1;
    cyc();
    chk("t1_gnt", alloc_gnt, 1'b1);
    chk("t1_way", alloc_way, 4'b0001);
    chk("t1_busy", busy, 1'b1);
    alloc_req = 1'b0;
    cyc();
    chk("t1_gnt_pulse", alloc_gnt, 1'b0);
    alloc_done = 1'b1;
    cyc();
    alloc_done = 1'b0;
    chk("t1_upd", lru_update, 1'b1);
    chk("t1_acc", lru_accessed_blk, 4'b0001);
    chk("t1_valid", valid_vec, 4'b0001);

    // Fill remaining ways, touch 1 and 2, then victim-based allocation.
    do_alloc(w, e); chk("t2_fill1", w, 4'b0010);
    do_alloc(w, e); chk("t2_fill2", w, 4'b0100);
    do_alloc(w, e); chk("t2_fill3", w, 4'b1000);
    cyc();
    chk("t2_valid_full", valid_vec, 4'b1111);
    hit_req = 1'b1; hit_way = 4'b0000;
    #1 chk("t2_zero_way", hit_gnt, 1'b0);
    hit_way = 4'b0010;
    #1 chk("t2_hit_gnt", hit_gnt, 1'b1);
    cyc();
    chk("t2_hit_upd", lru_update, 1'b1);
    chk("t2_hit_acc", lru_accessed_blk, 4'b0010);
    hit_way = 4'b0100;
    cyc();
    hit_req = 1'b0;
    cyc();
    chk("t2_stack_victim", lru_victim_blk, 4'b0001);
    do_alloc(w, e);
    chk("t2_victim_way", w, 4'b0001);
    chk("t2_err", e, 1'b0);
    cyc();

    // Starvation: three hits win, then the allocation is forced.
    starve_run(nh, w);
    chk("t3_hits", nh, 3);
    chk("t3_way", w, 4'b1000);
    cyc();
    starve_run(nh, w);
    chk("t3_hits_again", nh, 3);
    cyc();

    // Hits during an allocation of way 2.
    inval_req = 1'b1; inval_way = 4'b0100;
    cyc();
    inval_req = 1'b0;
    chk("t4_inval", valid_vec, 4'b1011);
    alloc_req = 1'b1;
    cyc();
    alloc_req = 1'b0;
    chk("t4_gnt", alloc_gnt, 1'b1);
    chk("t4_way", alloc_way, 4'b0100);
    hit_req = 1'b1; hit_way = 4'b0100;
    #1 chk("t4_same_grant", hit_gnt, 1'b0);
    cyc();
    #1 chk("t4_same_alloc", hit_gnt, 1'b0);
    hit_way = 4'b0010;
    #1 chk("t4_other", hit_gnt, 1'b1);
    cyc();
    chk("t4_other_upd", lru_update, 1'b1);
    chk("t4_other_acc", lru_accessed_blk, 4'b0010);
    alloc_done = 1'b1;
    #1 chk("t4_done_cycle", hit_gnt, 1'b0);
    cyc();
    hit_req = 1'b0; alloc_done = 1'b0;
    chk("t4_commit_acc", lru_accessed_blk, 4'b0100);
    chk("t4_commit_valid", valid_vec, 4'b1111);
    chk("t4_idle", busy, 1'b0);
    cyc();

    // Same-cycle invalidate steers selection; commit beats invalidate.
    alloc_req = 1'b1; inval_req = 1'b1; inval_way = 4'b0100;
    cyc();
    alloc_req = 1'b0; inval_req = 1'b0;
    chk("t5_way", alloc_way, 4'b0100);
    chk("t5_valid", valid_vec, 4'b1011);
    cyc();
    alloc_done = 1'b1; inval_req = 1'b1;
    cyc();
    alloc_done = 1'b0; inval_req = 1'b0;
    chk("t5_commit_wins", valid_vec, 4'b1111);
    chk("t5_upd", lru_update, 1'b1);
    cyc();

    // Non-one-hot victim with all ways valid.
    vic_ovr_en = 1'b1; vic_ovr = 4'b0011;
    alloc_req = 1'b1;
    cyc();
    alloc_req = 1'b0;
    chk("err_gnt", alloc_gnt, 1'b1);
    chk("err_pulse", alloc_err, 1'b1);
    chk("err_way", alloc_way, 4'b1000);
    cyc();
    chk("err_cleared", alloc_err, 1'b0);
    alloc_done = 1'b1;
    cyc();
    alloc_done = 1'b0; vic_ovr_en = 1'b0;
    cyc();

    // Reset in the middle of an allocation.
    alloc_req = 1'b1;
    cyc();
    alloc_req = 1'b0;
    cyc();
    chk("t6_in_alloc", busy, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_way", alloc_way, 4'b0000);
    chk("t6_valid", valid_vec, 4'b0000);
    chk("t6_upd", lru_update, 1'b0);
    cyc();
    rst_b = 1'b1;
    alloc_done = 1'b1;
    cyc();
    alloc_done = 1'b0;
    chk("t6_stray_upd", lru_update, 1'b0);
    chk("t6_stray_valid", valid_vec, 4'b0000);
    do_alloc(w, e);
    chk("t6_realloc", w, 4'b0001);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
